// File: rtl/referee_1.sv
// referee_1: four-to-one virtual-channel arbiter.
// Pops show-ahead VC FIFOs round-robin with a bounded burst per grant and
// pushes the popped words into one shared output FIFO, one cycle later.
module referee_1 #(
    parameter int LINE_SIZE = 12,
    parameter int BURST     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           empty_signal,
    input  logic                 almost_full_signal,
    input  logic [LINE_SIZE-1:0] data_in0,
    input  logic [LINE_SIZE-1:0] data_in1,
    input  logic [LINE_SIZE-1:0] data_in2,
    input  logic [LINE_SIZE-1:0] data_in3,
    output logic [3:0]           pop_signal,
    output logic                 push_signal,
    output logic [LINE_SIZE-1:0] data_out,
    output logic [1:0]           active_vc
);

    localparam logic [3:0] BURST_LIM = 4'(BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           last_vc_q, last_vc_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic                 push_q, push_d;
    logic [LINE_SIZE-1:0] data_q, data_d;
    logic [1:0]           vc_q, vc_d;

    logic [3:0]           eligible;
    logic [3:0]           pop_grant;
    logic [LINE_SIZE-1:0] data_in_arr [4];

    // Round-robin candidates: offset gi+1 from the last granted VC, so the
    // last candidate is the last VC itself (re-grant when it is the only one).
    logic [1:0]           cand [4];
    logic [3:0]           cand_ok;
    logic [1:0]           rr_pick;
    logic                 rr_found;

    assign eligible       = ~empty_signal;
    assign data_in_arr[0] = data_in0;
    assign data_in_arr[1] = data_in1;
    assign data_in_arr[2] = data_in2;
    assign data_in_arr[3] = data_in3;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand[gi]    = last_vc_q + 2'(gi + 1);
        assign cand_ok[gi] = eligible[cand[gi]];
    end

    // Pick the first eligible VC in rotation order after last_vc.
    always_comb begin
        rr_pick  = last_vc_q;
        rr_found = 1'b1;
        if (cand_ok[0]) begin
            rr_pick = cand[0];
        end else if (cand_ok[1]) begin
            rr_pick = cand[1];
        end else if (cand_ok[2]) begin
            rr_pick = cand[2];
        end else if (cand_ok[3]) begin
            rr_pick = cand[3];
        end else begin
            rr_found = 1'b0;
        end
    end

    // Grant FSM next-state: burst continuation, rotation and backpressure.
    always_comb begin
        state_d     = state_q;
        last_vc_d   = last_vc_q;
        burst_cnt_d = burst_cnt_q;
        pop_grant   = 4'b0000;
        case (state_q)
            IDLE: begin
                if (!almost_full_signal && rr_found) begin
                    pop_grant[rr_pick] = 1'b1;
                    last_vc_d          = rr_pick;
                    burst_cnt_d        = 4'd1;
                    state_d            = SERVE;
                end
            end
            SERVE: begin
                if (almost_full_signal) begin
                    // Burst count is kept; the next grant rotates anyway.
                    state_d = IDLE;
                end else if (eligible[last_vc_q] && (burst_cnt_q < BURST_LIM)) begin
                    pop_grant[last_vc_q] = 1'b1;
                    burst_cnt_d          = burst_cnt_q + 4'd1;
                end else if (rr_found) begin
                    pop_grant[rr_pick] = 1'b1;
                    last_vc_d          = rr_pick;
                    burst_cnt_d        = 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next-state: capture the popped head word and its VC index.
    // Whenever a pop is granted, last_vc_d holds the popped VC.
    always_comb begin
        push_d = |pop_grant;
        data_d = data_q;
        vc_d   = vc_q;
        if (|pop_grant) begin
            data_d = data_in_arr[last_vc_d];
            vc_d   = last_vc_d;
        end
    end

    // All state and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_vc_q   <= 2'd3;
            burst_cnt_q <= 4'd0;
            push_q      <= 1'b0;
            data_q      <= '0;
            vc_q        <= 2'd0;
        end else begin
            state_q     <= state_d;
            last_vc_q   <= last_vc_d;
            burst_cnt_q <= burst_cnt_d;
            push_q      <= push_d;
            data_q      <= data_d;
            vc_q        <= vc_d;
        end
    end

    // Pop is combinational; gating with reset drops it in the reset cycle.
    assign pop_signal  = reset ? 4'b0000 : pop_grant;
    assign push_signal = push_q;
    assign data_out    = data_q;
    assign active_vc   = vc_q;

endmodule

// File: tb/tb_referee_1.sv
// Self-checking bench for referee_1: modelled VC FIFOs, expected grant
// sequences per scenario and a scoreboard of expected pushed words.
module tb_referee_1;

    localparam int LS = 12;

    logic          clk;
    logic          reset;
    logic [3:0]    empty_signal;
    logic          almost_full_signal;
    logic [LS-1:0] data_in0, data_in1, data_in2, data_in3;
    logic [3:0]    pop_signal;
    logic          push_signal;
    logic [LS-1:0] data_out;
    logic [1:0]    active_vc;

    referee_1 #(.LINE_SIZE(LS), .BURST(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .empty_signal       (empty_signal),
        .almost_full_signal (almost_full_signal),
        .data_in0           (data_in0),
        .data_in1           (data_in1),
        .data_in2           (data_in2),
        .data_in3           (data_in3),
        .pop_signal         (pop_signal),
        .push_signal        (push_signal),
        .data_out           (data_out),
        .active_vc          (active_vc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    string         tname  = "init";
    logic [LS-1:0] mem [4][16];
    int            rd [4];
    int            wr [4];
    logic          af = 1'b0;
    logic          exp_push = 1'b0;
    logic [LS+1:0] sb [$];

    function automatic int decode(input logic [3:0] p);
        case (p)
            4'b0000: return -1;
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -2;
        endcase
    endfunction

    function automatic logic [LS-1:0] head(input int v);
        if (rd[v] < wr[v]) return mem[v][rd[v]];
        return '0;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) empty_signal[i] = (rd[i] >= wr[i]);
        data_in0           = head(0);
        data_in1           = head(1);
        data_in2           = head(2);
        data_in3           = head(3);
        almost_full_signal = af;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
    endtask

    task automatic load(input int v, input int n);
        for (int j = 0; j < n; j++) begin
            mem[v][wr[v]] = LS'(((v + 1) << 8) + j + 1);
            wr[v]++;
        end
    endtask

    // One clock cycle: expect a pop of VC e (-1 = no pop) and check the push
    // owed by the previous cycle against the scoreboard.
    task automatic step(input int e);
        logic [3:0]    pop_s;
        logic [LS+1:0] exp_w;
        int            got;
        drive_inputs();
        @(negedge clk);
        pop_s = pop_signal;
        got   = decode(pop_s);
        checks++;
        if (got != e) begin
            errors++;
            $display("FAIL %s pop: got %b, expected vc %0d", tname, pop_s, e);
        end
        if (exp_push) begin
            exp_w = sb.pop_front();
            checks++;
            if (push_signal !== 1'b1 || {active_vc, data_out} !== exp_w) begin
                errors++;
                $display("FAIL %s push: got push=%b vc=%0d data=%h, expected push=1 vc=%0d data=%h",
                         tname, push_signal, active_vc, data_out, exp_w[LS+1:LS], exp_w[LS-1:0]);
            end else begin
                $display("%s push vc=%0d data=%h", tname, active_vc, data_out);
            end
        end else begin
            checks++;
            if (push_signal !== 1'b0) begin
                errors++;
                $display("FAIL %s idle push: got %b, expected 0", tname, push_signal);
            end
        end
        exp_push = (e >= 0);
        if (e >= 0) sb.push_back({e[1:0], head(e)});
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (pop_s[i] && rd[i] < wr[i]) rd[i]++;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        af    = 1'b0;
        clear_fifos();
        sb.delete();
        exp_push = 1'b0;
        drive_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tname = "reset";
        reset = 1'b1;
        clear_fifos();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pop_signal !== 4'b0000) begin errors++; $display("FAIL reset pop: got %b, expected 0000", pop_signal); end
        checks++;
        if (push_signal !== 1'b0) begin errors++; $display("FAIL reset push: got %b, expected 0", push_signal); end
        checks++;
        if (data_out !== '0) begin errors++; $display("FAIL reset data_out: got %h, expected 000", data_out); end
        checks++;
        if (active_vc !== 2'd0) begin errors++; $display("FAIL reset active_vc: got %0d, expected 0", active_vc); end
        reset = 1'b0;
    endtask

    task automatic test_single_vc();
        tname = "single";
        mem[2][0] = 12'hA01;
        mem[2][1] = 12'hA02;
        wr[2] = 2;
        step(2); step(2); step(-1); step(-1);
    endtask

    task automatic test_rr_burst();
        int order [24] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0, 1,1, 2,2, 3,3};
        tname = "rr_burst";
        apply_reset();
        for (int v = 0; v < 4; v++) load(v, 6);
        for (int k = 0; k < 24; k++) step(order[k]);
        step(-1); step(-1);
    endtask

    task automatic test_backpressure();
        tname = "backpressure";
        apply_reset();
        load(1, 4);
        load(2, 2);
        step(1); step(1);
        af = 1'b1;
        step(-1); step(-1); step(-1);
        af = 1'b0;
        step(2); step(2); step(1); step(1); step(-1); step(-1);
    endtask

    task automatic test_sole_vc();
        tname = "sole";
        apply_reset();
        load(3, 10);
        for (int k = 0; k < 10; k++) step(3);
        step(-1); step(-1);
    endtask

    task automatic test_reset_mid();
        tname = "reset_mid";
        apply_reset();
        load(0, 4);
        load(1, 1);
        step(0); step(0);
        drive_inputs();
        #1;
        checks++;
        if (pop_signal !== 4'b0001 || push_signal !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre: got pop=%b push=%b, expected pop=0001 push=1", pop_signal, push_signal);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (pop_signal !== 4'b0000) begin errors++; $display("FAIL reset_mid pop: got %b, expected 0000", pop_signal); end
        checks++;
        if (push_signal !== 1'b0) begin errors++; $display("FAIL reset_mid push: got %b, expected 0", push_signal); end
        checks++;
        if (data_out !== '0 || active_vc !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid regs: got data=%h vc=%0d, expected 000 and 0", data_out, active_vc);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_push = 1'b0;
        step(0); step(0); step(1); step(-1); step(-1);
    endtask

    task automatic test_empty_race();
        tname = "empty_race";
        apply_reset();
        load(0, 4);
        load(1, 2);
        load(3, 2);
        step(0); step(0); step(0); step(0);
        step(1); step(1); step(3); step(3); step(-1); step(-1);
    endtask

    initial begin
        reset = 1'b1;
        clear_fifos();
        drive_inputs();
        test_reset();
        test_single_vc();
        test_rr_burst();
        test_backpressure();
        test_sole_vc();
        test_reset_mid();
        test_empty_race();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
